// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int NUM_PORTS  = 2;
    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;
    localparam int CNT_W      = 4;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin: on a tie the port that did not win last time is granted.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
    input  logic                 rr_last,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 gnt_idx
);

    always_comb begin
        gnt     = '0;
        gnt_idx = 1'b0;
        case (valid)
            2'b01: gnt = 2'b01;
            2'b10: begin
                gnt     = 2'b10;
                gnt_idx = 1'b1;
            end
            2'b11: begin
                gnt_idx = ~rr_last;
                gnt     = port_onehot(~rr_last);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch/data requests onto a single fixed-latency memory port,
// one transaction in flight, one response pulse per accepted request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [NUM_PORTS-1:0]                  req_valid,
    output logic [NUM_PORTS-1:0]                  req_ready,
    input  logic [NUM_PORTS-1:0]                  req_we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]      req_wdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]    req_wstrb,
    output logic [NUM_PORTS-1:0]                  rsp_valid,
    output logic [DATA_W-1:0]                     rsp_rdata,
    output logic                                  mem_en,
    output logic                                  mem_we,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic [DATA_W-1:0]                     mem_wdata,
    output logic [DATA_W/8-1:0]                   mem_wstrb,
    input  logic [DATA_W-1:0]                     mem_rdata
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    arb_state_e             state_q,     state_d;
    logic                   rr_last_q,   rr_last_d;
    logic                   owner_q,     owner_d;
    logic                   we_q,        we_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic                   mem_en_q,    mem_en_d;
    logic                   mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]    mem_wstrb_q, mem_wstrb_d;
    logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;

    logic [NUM_PORTS-1:0]   gnt;
    logic                   gnt_idx;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .rr_last (rr_last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rsp_valid_d = '0;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    // The mem_* registers double as the request latch.
                    owner_d     = gnt_idx;
                    rr_last_d   = gnt_idx;
                    we_d        = req_we[gnt_idx];
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_we[gnt_idx];
                    mem_addr_d  = req_addr[gnt_idx];
                    mem_wdata_d = req_wdata[gnt_idx];
                    mem_wstrb_d = req_wstrb[gnt_idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = CNT_INIT;
                if (MEM_LATENCY == 1) begin
                    state_d     = RESP;
                    rsp_valid_d = port_onehot(owner_q);
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Leaving on cnt==1 lands RESP exactly MEM_LATENCY cycles after ISSUE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = RESP;
                    rsp_valid_d = port_onehot(owner_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    // Read data arrives in the RESP cycle itself, so it is passed through, not registered.
    assign rsp_rdata = (|rsp_valid_q && !we_q) ? mem_rdata : '0;

endmodule
